// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use / branch-operand hazards and I/D-cache miss freezes.
// Latency: control outputs are combinational (0 cycles); state and counters update on clk.
// Backpressure: D-miss freezes the whole pipe, I-miss holds PC and feeds NOPs, hazards bubble ID/EX.
module hazard_stall_unit #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_ADDR-1:0] if_id_src1,
  input  logic [REG_ADDR-1:0] if_id_src2,
  input  logic                if_id_use_src2,
  input  logic                if_id_is_branch,
  input  logic                branch_taken,
  input  logic                id_ex_memread,
  input  logic                id_ex_regwrite,
  input  logic [REG_ADDR-1:0] id_ex_dst_reg,
  input  logic                ex_mem_memread,
  input  logic [REG_ADDR-1:0] ex_mem_dst_reg,
  input  logic                icache_ready,
  input  logic                dcache_req,
  input  logic                dcache_ready,
  input  logic                perf_clr,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                pipe_write,
  output logic                mem_wb_bubble,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    bubble_count,
  output logic [CNT_W-1:0]    miss_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             d_stall, i_stall, load_use, br_haz, miss_now;

  // True when an ID source register is produced by dst; r0 never matches.
  function automatic logic src_match(input logic [REG_ADDR-1:0] dst,
                                     input logic [REG_ADDR-1:0] s1,
                                     input logic [REG_ADDR-1:0] s2,
                                     input logic                use2);
    src_match = (dst != '0) && ((dst == s1) || (use2 && (dst == s2)));
  endfunction

  // Hazard and miss detection; a D-miss stays frozen until ready even if the request drops.
  always_comb begin
    d_stall  = !dcache_ready && (dcache_req || (state_q == DMISS));
    i_stall  = !icache_ready;
    load_use = id_ex_memread &&
               src_match(id_ex_dst_reg, if_id_src1, if_id_src2, if_id_use_src2);
    br_haz   = if_id_is_branch &&
               ((id_ex_regwrite &&
                 src_match(id_ex_dst_reg, if_id_src1, if_id_src2, if_id_use_src2)) ||
                (ex_mem_memread &&
                 src_match(ex_mem_dst_reg, if_id_src1, if_id_src2, if_id_use_src2)));
  end

  // Prioritised control outputs and next state: D-miss > I-miss > hazard > flush.
  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_write    = 1'b0;
    mem_wb_bubble = 1'b0;
    miss_now      = 1'b0;
    state_d       = RUN;
    if (!rst_n) begin
      state_d = RUN;
    end else if (d_stall) begin
      mem_wb_bubble = 1'b1;
      miss_now      = 1'b1;
      state_d       = DMISS;
    end else if (i_stall) begin
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      pipe_write  = 1'b1;
      miss_now    = 1'b1;
      state_d     = IMISS;
    end else if (load_use || br_haz) begin
      id_ex_bubble = 1'b1;
      pipe_write   = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      pipe_write  = 1'b1;
      if_id_flush = branch_taken && if_id_is_branch;
    end
  end

  // Wrapping performance counters; a clear overrides any increment in the same cycle.
  always_comb begin
    if (perf_clr) begin
      stall_d  = '0;
      bubble_d = '0;
      miss_d   = '0;
    end else begin
      stall_d  = stall_q  + {{(CNT_W-1){1'b0}}, !pc_write};
      bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, id_ex_bubble};
      miss_d   = miss_q   + {{(CNT_W-1){1'b0}}, miss_now};
    end
  end

  // State and counter registers; reset drops any pending miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      stall_q  <= '0;
      bubble_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      miss_q   <= miss_d;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
  assign miss_cycles  = miss_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] if_id_src1, if_id_src2, id_ex_dst_reg, ex_mem_dst_reg;
  logic       if_id_use_src2, if_id_is_branch, branch_taken;
  logic       id_ex_memread, id_ex_regwrite, ex_mem_memread;
  logic       icache_ready, dcache_req, dcache_ready, perf_clr;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write, mem_wb_bubble;
  logic [31:0] stall_cycles, bubble_count, miss_cycles;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_write, s_mem_wb_bubble;
  logic [2:0]  s_stall, s_bubble, s_miss;

  hazard_stall_unit dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2),
    .if_id_use_src2(if_id_use_src2), .if_id_is_branch(if_id_is_branch),
    .branch_taken(branch_taken), .id_ex_memread(id_ex_memread),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_dst_reg(id_ex_dst_reg),
    .ex_mem_memread(ex_mem_memread), .ex_mem_dst_reg(ex_mem_dst_reg),
    .icache_ready(icache_ready), .dcache_req(dcache_req),
    .dcache_ready(dcache_ready), .perf_clr(perf_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_write(pipe_write),
    .mem_wb_bubble(mem_wb_bubble), .stall_cycles(stall_cycles),
    .bubble_count(bubble_count), .miss_cycles(miss_cycles)
  );

  // Narrow-counter instance: exposes modulo wrap within a short run.
  hazard_stall_unit #(.REG_ADDR(5), .CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2),
    .if_id_use_src2(if_id_use_src2), .if_id_is_branch(if_id_is_branch),
    .branch_taken(branch_taken), .id_ex_memread(id_ex_memread),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_dst_reg(id_ex_dst_reg),
    .ex_mem_memread(ex_mem_memread), .ex_mem_dst_reg(ex_mem_dst_reg),
    .icache_ready(icache_ready), .dcache_req(dcache_req),
    .dcache_ready(dcache_ready), .perf_clr(perf_clr),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .pipe_write(s_pipe_write),
    .mem_wb_bubble(s_mem_wb_bubble), .stall_cycles(s_stall),
    .bubble_count(s_bubble), .miss_cycles(s_miss)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        pend_m;   // D-cache access still outstanding from an earlier cycle
  logic [31:0] st_m, bub_m, mis_m;

  function automatic logic dep(input logic [4:0] dst);
    return (dst != 5'd0) && (dst == if_id_src1 || (if_id_use_src2 && dst == if_id_src2));
  endfunction

  function automatic logic dfrozen();
    return !dcache_ready && (dcache_req || pend_m);
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write, mem_wb_bubble}
  function automatic logic [5:0] exp_ctrl();
    logic hz;
    hz = (id_ex_memread && dep(id_ex_dst_reg)) ||
         (if_id_is_branch && ((id_ex_regwrite && dep(id_ex_dst_reg)) ||
                              (ex_mem_memread && dep(ex_mem_dst_reg))));
    if (!rst_n)         return 6'b000000;
    if (dfrozen())      return 6'b000001;
    if (!icache_ready)  return 6'b011010;
    if (hz)             return 6'b000110;
    return {2'b11, branch_taken && if_id_is_branch, 3'b010};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_m <= 1'b0;
      st_m   <= 32'd0;
      bub_m  <= 32'd0;
      mis_m  <= 32'd0;
    end else begin
      pend_m <= dfrozen();
      if (perf_clr) begin
        st_m  <= 32'd0;
        bub_m <= 32'd0;
        mis_m <= 32'd0;
      end else begin
        st_m  <= st_m  + (exp_ctrl() >> 5 == 6'd0 ? 32'd1 : 32'd0);
        bub_m <= bub_m + {31'd0, exp_ctrl() == 6'b000110};
        mis_m <= mis_m + {31'd0, dfrozen() || !icache_ready};
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ctrl", {26'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write, mem_wb_bubble},
          {26'd0, exp_ctrl()});
    check("stall_cycles", stall_cycles, st_m);
    check("bubble_count", bubble_count, bub_m);
    check("miss_cycles",  miss_cycles,  mis_m);
    check("w_stall",  {29'd0, s_stall},  {29'd0, st_m[2:0]});
    check("w_bubble", {29'd0, s_bubble}, {29'd0, bub_m[2:0]});
    check("w_miss",   {29'd0, s_miss},   {29'd0, mis_m[2:0]});
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    if_id_src1 = 5'd0; if_id_src2 = 5'd0; if_id_use_src2 = 1'b0;
    if_id_is_branch = 1'b0; branch_taken = 1'b0;
    id_ex_memread = 1'b0; id_ex_regwrite = 1'b0; id_ex_dst_reg = 5'd0;
    ex_mem_memread = 1'b0; ex_mem_dst_reg = 5'd0;
    icache_ready = 1'b1; dcache_req = 1'b0; dcache_ready = 1'b1; perf_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic clear_cycle();
    step();
    perf_clr = 1'b1;
    step();
  endtask

  task automatic load_use_r3();
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd3; if_id_src1 = 5'd3;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    dcache_req = 1'b1; dcache_ready = 1'b0;
    #12;
    check("rst_pc_write", {31'd0, pc_write}, 32'd0);
    check("rst_mem_wb_bubble", {31'd0, mem_wb_bubble}, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("run_pc_write", {31'd0, pc_write}, 32'd1);

    // load-use on r3
    clear_cycle();
    load_use_r3();
    #1;
    check("lu_pc_write", {31'd0, pc_write}, 32'd0);
    check("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    step(); #1;
    check("lu_count", bubble_count, 32'd1);

    // ALU r5 then beq r5 (1 stall), lw r5 then beq r5 (2 stalls)
    clear_cycle();
    id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd5;
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5; branch_taken = 1'b1;
    #1;
    check("alu_br_pc", {31'd0, pc_write}, 32'd0);
    check("alu_br_noflush", {31'd0, if_id_flush}, 32'd0);
    step();
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5; branch_taken = 1'b1;
    #1;
    check("br_taken_flush", {31'd0, if_id_flush}, 32'd1);
    step();
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_dst_reg = 5'd5;
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5;
    #1;
    check("lw_br_stall1", {31'd0, pc_write}, 32'd0);
    step();
    ex_mem_memread = 1'b1; ex_mem_dst_reg = 5'd5;
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5;
    #1;
    check("lw_br_stall2", {31'd0, pc_write}, 32'd0);
    step();
    if_id_is_branch = 1'b1; if_id_src1 = 5'd5;
    #1;
    check("lw_br_go", {31'd0, pc_write}, 32'd1);
    check("br_bubbles", bubble_count, 32'd3);

    // 4-cycle D-miss
    clear_cycle();
    for (int i = 0; i < 4; i++) begin
      dcache_req = 1'b1; dcache_ready = 1'b0;
      #1;
      check("dm_mwb", {31'd0, mem_wb_bubble}, 32'd1);
      step();
    end
    dcache_req = 1'b1; dcache_ready = 1'b1;
    #1;
    check("dm_done_pc", {31'd0, pc_write}, 32'd1);
    check("dm_miss_cycles", miss_cycles, 32'd4);
    check("dm_stall_cycles", stall_cycles, 32'd4);

    // I-miss overrides a load-use hazard, hazard resolves afterwards
    clear_cycle();
    for (int i = 0; i < 3; i++) begin
      load_use_r3(); icache_ready = 1'b0;
      #1;
      check("im_flush", {31'd0, if_id_flush}, 32'd1);
      check("im_nobubble", {31'd0, id_ex_bubble}, 32'd0);
      step();
    end
    load_use_r3();
    #1;
    check("im_then_bubble", {31'd0, id_ex_bubble}, 32'd1);
    step(); #1;
    check("im_miss_cycles", miss_cycles, 32'd3);

    // D-miss during I-miss: DMISS, then IMISS, then RUN
    step();
    icache_ready = 1'b0;
    #1;
    check("di_imiss", {31'd0, if_id_flush}, 32'd1);
    step();
    icache_ready = 1'b0; dcache_req = 1'b1; dcache_ready = 1'b0;
    #1;
    check("di_dmiss", {31'd0, mem_wb_bubble}, 32'd1);
    step();
    icache_ready = 1'b0; dcache_req = 1'b0; dcache_ready = 1'b0;
    #1;
    check("di_pending_frozen", {31'd0, mem_wb_bubble}, 32'd1);
    step();
    icache_ready = 1'b0; dcache_req = 1'b1; dcache_ready = 1'b1;
    #1;
    check("di_back_imiss", {31'd0, if_id_flush}, 32'd1);
    step(); #1;
    check("di_run", {31'd0, pc_write}, 32'd1);

    // reset during a D-miss forgets it
    step();
    dcache_req = 1'b1; dcache_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_pc", {31'd0, pc_write}, 32'd0);
    step();
    rst_n = 1'b1; dcache_ready = 1'b0;
    #1;
    check("rst_forgot_miss", {31'd0, pc_write}, 32'd1);

    // wrap on the 3-bit instance; clear beats a simultaneous stall
    clear_cycle();
    for (int i = 0; i < 8; i++) begin
      load_use_r3();
      step();
    end
    #1;
    check("wrap_w_stall", {29'd0, s_stall}, 32'd0);
    check("wrap_stall", stall_cycles, 32'd8);
    load_use_r3(); perf_clr = 1'b1;
    step(); #1;
    check("clr_wins_stall", stall_cycles, 32'd0);
    check("clr_wins_bubble", bubble_count, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n           = ($urandom_range(399) != 0);
      if_id_src1      = 5'($urandom_range(3));
      if_id_src2      = 5'($urandom_range(3));
      if_id_use_src2  = 1'($urandom_range(1));
      if_id_is_branch = ($urandom_range(2) == 0);
      branch_taken    = 1'($urandom_range(1));
      id_ex_memread   = ($urandom_range(2) == 0);
      id_ex_regwrite  = 1'($urandom_range(1));
      id_ex_dst_reg   = 5'($urandom_range(3));
      ex_mem_memread  = ($urandom_range(2) == 0);
      ex_mem_dst_reg  = 5'($urandom_range(3));
      icache_ready    = ($urandom_range(5) != 0);
      dcache_req      = ($urandom_range(2) == 0);
      dcache_ready    = ($urandom_range(2) != 0);
      perf_clr        = ($urandom_range(49) == 0);
    end
    step();
    rst_n = 1'b1;
    step();
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
